// File: rtl/stream_pair_accumulate.sv
// Consumer-side generator: pulls (a,b) pairs from upstream, accumulates a+b, and
// yields (total,count) downstream whenever the running total exceeds a threshold.
module stream_pair_accumulate (
    input  logic               _clock,
    input  logic               _reset,
    input  logic               _start,
    input  logic signed [31:0] threshold,
    input  logic               _ready,
    output logic               _valid,
    output logic               _done,
    output logic signed [31:0] _0,
    output logic signed [31:0] _1,
    input  logic signed [31:0] _in_0,
    input  logic signed [31:0] _in_1,
    input  logic               _in_valid,
    input  logic               _in_done,
    output logic               _in_ready
);

    typedef enum logic [1:0] {PULL, FLUSH, DONE} state_t;

    state_t             state;
    logic signed [31:0] thr;
    logic signed [31:0] total;
    logic signed [31:0] count;
    logic signed [31:0] sum;
    logic               advance;
    logic               xfer;

    // A held output tuple blocks everything until downstream takes it.
    assign advance   = _ready || !_valid;
    assign _in_ready = (state == PULL) && advance && !_start;
    assign xfer      = _in_ready && _in_valid;
    assign sum       = total + _in_0 + _in_1;

    always_ff @(posedge _clock) begin
        _done <= 1'b0;
        if (_ready) begin
            _valid <= 1'b0;
        end

        if (_start) begin
            thr    <= threshold;
            total  <= '0;
            count  <= '0;
            _valid <= 1'b0;
            state  <= PULL;
        end else if (_reset) begin
            state  <= DONE;
            _valid <= 1'b0;
            _0     <= '0;
            _1     <= '0;
            total  <= '0;
            count  <= '0;
        end else if (advance) begin
            case (state)
                PULL: begin
                    // A transfer in the same cycle as _in_done wins; done is seen next cycle.
                    if (xfer) begin
                        count <= count + 32'sd1;
                        if (sum > thr) begin
                            _0     <= sum;
                            _1     <= count + 32'sd1;
                            _valid <= 1'b1;
                            total  <= '0;
                        end else begin
                            total <= sum;
                        end
                    end else if (_in_done) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    _0     <= total;
                    _1     <= count;
                    _valid <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    _done <= 1'b1;
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule
